// File: rtl/field_pkg.sv
// Shared types and constants for the asteroid field renderer.
package field_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_DONE} state_t;

    // Velocities are sign-extended into this container before the wrap adder.
    typedef logic signed [15:0] vel_t;

    // 12-bit RGB (4:4:4), indexed by slot id; entry 15 is leftmost.
    localparam logic [15:0][11:0] PALETTE = {
        12'h888, 12'h0F8, 12'hF08, 12'h8F0,
        12'h08F, 12'hF80, 12'h80F, 12'hFFF,
        12'h0FF, 12'hF0F, 12'hFF0, 12'h00F,
        12'h0F0, 12'hF00, 12'hCA4, 12'hE52
    };

endpackage

// File: rtl/wrap_step.sv
// One axis of object motion: pos + vel, wrapped into [0, LIM].
module wrap_step
    import field_pkg::*;
#(
    parameter int PW  = 10,
    parameter int LIM = 608
) (
    input  logic [PW-1:0] pos,
    input  vel_t          vel,
    output logic [PW-1:0] nxt
);

    localparam logic signed [31:0] LIM_S = 32'(LIM);
    localparam logic signed [31:0] SPAN  = 32'(LIM + 1);

    logic signed [31:0] sum;
    logic signed [31:0] wrapped;

    always_comb begin
        sum     = $signed({{(32-PW){1'b0}}, pos}) + 32'(vel);
        wrapped = sum;
        if (sum < 0)
            wrapped = sum + SPAN;
        else if (sum > LIM_S)
            wrapped = sum - SPAN;
        nxt = PW'(wrapped);
    end

endmodule

// File: rtl/asteroid_field.sv
// Object slot table with per-frame motion update, spawn/kill control and a
// 2-stage pixel hit/palette pipeline.
module asteroid_field
    import field_pkg::*;
#(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int N_OBJ    = 8,
    parameter int OBJ_W    = 32,
    parameter int OBJ_H    = 32,
    parameter int VEL_BITS = 4
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic [$clog2(WIDTH)-1:0]    pxl_x,
    input  logic [$clog2(HEIGHT)-1:0]   pxl_y,
    input  logic                        frame_start,
    input  logic                        spawn_valid,
    output logic                        spawn_ready,
    input  logic [$clog2(WIDTH)-1:0]    spawn_x,
    input  logic [$clog2(HEIGHT)-1:0]   spawn_y,
    input  logic signed [VEL_BITS-1:0]  spawn_vx,
    input  logic signed [VEL_BITS-1:0]  spawn_vy,
    input  logic                        kill_valid,
    input  logic [$clog2(N_OBJ)-1:0]    kill_id,
    output logic [3:0]                  Red,
    output logic [3:0]                  Green,
    output logic [3:0]                  Blue,
    output logic                        Draw,
    output logic [$clog2(N_OBJ)-1:0]    hit_id,
    output logic [N_OBJ-1:0]            active_mask
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(N_OBJ);
    localparam logic [XW-1:0] BOX_W = XW'(OBJ_W);
    localparam logic [YW-1:0] BOX_H = YW'(OBJ_H);

    state_t  state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;

    logic [N_OBJ-1:0]                active;
    logic [N_OBJ-1:0][XW-1:0]        pos_x;
    logic [N_OBJ-1:0][YW-1:0]        pos_y;
    logic [N_OBJ-1:0][VEL_BITS-1:0]  vel_x;
    logic [N_OBJ-1:0][VEL_BITS-1:0]  vel_y;

    logic [IW-1:0] free_idx;
    logic          any_free, spawn_acc, upd_en;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    assign active_mask = active;
    assign any_free    = ~&active;
    assign spawn_acc   = spawn_valid & spawn_ready & any_free;

    always_comb begin
        free_idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--)
            if (!active[i]) free_idx = IW'(i);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        upd_en    = 1'b0;
        case (state)
            ST_IDLE: if (frame_start) begin
                state_nxt = ST_UPDATE;
                idx_nxt   = '0;
            end
            ST_UPDATE: begin
                // A kill landing on the visited slot suppresses its move.
                upd_en = active[idx] && !(kill_valid && kill_id == idx);
                if (int'(idx) == N_OBJ - 1) state_nxt = ST_DONE;
                else                        idx_nxt   = idx + 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            idx         <= '0;
            spawn_ready <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            spawn_ready <= (state == ST_IDLE) && any_free;
        end
    end

    wrap_step #(.PW(XW), .LIM(WIDTH - OBJ_W)) u_wrap_x (
        .pos (pos_x[idx]),
        .vel (vel_t'($signed(vel_x[idx]))),
        .nxt (x_nxt)
    );

    wrap_step #(.PW(YW), .LIM(HEIGHT - OBJ_H)) u_wrap_y (
        .pos (pos_y[idx]),
        .vel (vel_t'($signed(vel_y[idx]))),
        .nxt (y_nxt)
    );

    // Kill is applied last so it overrides both the update and a spawn.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active <= '0;
            pos_x  <= '0;
            pos_y  <= '0;
            vel_x  <= '0;
            vel_y  <= '0;
        end else begin
            if (upd_en) begin
                pos_x[idx] <= x_nxt;
                pos_y[idx] <= y_nxt;
            end
            if (spawn_acc) begin
                pos_x[free_idx]  <= spawn_x;
                pos_y[free_idx]  <= spawn_y;
                vel_x[free_idx]  <= spawn_vx;
                vel_y[free_idx]  <= spawn_vy;
                active[free_idx] <= 1'b1;
            end
            if (kill_valid)
                active[kill_id] <= 1'b0;
        end
    end

    logic [N_OBJ-1:0] hit;
    logic [IW-1:0]    hit_sel;
    logic             s1_draw;
    logic [IW-1:0]    s1_id;
    logic [11:0]      rgb;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
        assign hit[g] = active[g]
                     && pxl_x >= pos_x[g] && (pxl_x - pos_x[g]) < BOX_W
                     && pxl_y >= pos_y[g] && (pxl_y - pos_y[g]) < BOX_H;
    end

    always_comb begin
        hit_sel = '0;
        for (int i = N_OBJ - 1; i >= 0; i--)
            if (hit[i]) hit_sel = IW'(i);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_draw <= 1'b0;
            s1_id   <= '0;
            Draw    <= 1'b0;
            hit_id  <= '0;
            rgb     <= '0;
        end else begin
            s1_draw <= |hit;
            s1_id   <= hit_sel;
            Draw    <= s1_draw;
            hit_id  <= s1_draw ? s1_id : '0;
            rgb     <= s1_draw ? PALETTE[4'(s1_id)] : 12'h000;
        end
    end

    assign Red   = rgb[11:8];
    assign Green = rgb[7:4];
    assign Blue  = rgb[3:0];

endmodule

// File: tb/tb_asteroid_field.sv
// Bench for asteroid_field: directed scenarios, a probe table and random ops
// checked against an array-based model of the object field.
module tb_asteroid_field;
    import field_pkg::*;

    localparam int N  = 8;
    localparam int LX = 640 - 32;
    localparam int LY = 480 - 32;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic [9:0]        pxl_x = '0;
    logic [8:0]        pxl_y = '0;
    logic              frame_start = 1'b0;
    logic              spawn_valid = 1'b0;
    logic              spawn_ready;
    logic [9:0]        spawn_x = '0;
    logic [8:0]        spawn_y = '0;
    logic signed [3:0] spawn_vx = '0;
    logic signed [3:0] spawn_vy = '0;
    logic              kill_valid = 1'b0;
    logic [2:0]        kill_id = '0;
    logic [3:0]        Red, Green, Blue;
    logic              Draw;
    logic [2:0]        hit_id;
    logic [7:0]        active_mask;

    asteroid_field dut (
        .clk(clk), .resetN(resetN), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .frame_start(frame_start), .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_vx(spawn_vx), .spawn_vy(spawn_vy), .kill_valid(kill_valid),
        .kill_id(kill_id), .Red(Red), .Green(Green), .Blue(Blue),
        .Draw(Draw), .hit_id(hit_id), .active_mask(active_mask)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int m_act[N], m_x[N], m_y[N], m_vx[N], m_vy[N];

    typedef struct {
        int px;
        int py;
        bit draw;
        int id;
    } probe_vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
        end
    endtask

    function automatic int m_free();
        for (int i = 0; i < N; i++) if (m_act[i] == 0) return i;
        return -1;
    endfunction

    function automatic int wrapv(input int p, input int v, input int lim);
        int s = p + v;
        if (s < 0) s += lim + 1;
        else if (s > lim) s -= lim + 1;
        return s;
    endfunction

    function automatic int m_mask();
        int m = 0;
        for (int i = 0; i < N; i++) if (m_act[i] != 0) m |= (1 << i);
        return m;
    endfunction

    task automatic m_insert(input int x, input int y, input int vx, input int vy);
        int f = m_free();
        if (f >= 0) begin
            m_act[f] = 1; m_x[f] = x; m_y[f] = y; m_vx[f] = vx; m_vy[f] = vy;
        end
    endtask

    task automatic m_frame(input int kslot);
        for (int i = 0; i < N; i++) begin
            if (i == kslot) m_act[i] = 0;
            else if (m_act[i] != 0) begin
                m_x[i] = wrapv(m_x[i], m_vx[i], LX);
                m_y[i] = wrapv(m_y[i], m_vy[i], LY);
            end
        end
    endtask

    task automatic check_state(input string nm);
        check({nm, ".mask"}, 32'(active_mask), 32'(m_mask()));
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.x%0d", nm, i), 32'(dut.pos_x[i]), 32'(m_x[i]));
            check($sformatf("%s.y%0d", nm, i), 32'(dut.pos_y[i]), 32'(m_y[i]));
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        m_reset();
        tick();
    endtask

    task automatic do_spawn(input int x, input int y, input int vx, input int vy, input int kid);
        int f = m_free();
        spawn_x = 10'(x); spawn_y = 9'(y); spawn_vx = 4'(vx); spawn_vy = 4'(vy);
        spawn_valid = 1'b1;
        if (kid >= 0) begin kill_valid = 1'b1; kill_id = 3'(kid); end
        if (f >= 0) check("spawn_ready", 32'(spawn_ready), 32'd1);
        tick();
        spawn_valid = 1'b0;
        kill_valid = 1'b0;
        m_insert(x, y, vx, vy);
        if (kid >= 0) m_act[kid] = 0;
        tick();
    endtask

    task automatic frame(input int kslot, input bit sp, input int sx, input int sy,
                         input int svx, input int svy);
        frame_start = 1'b1;
        if (sp) begin
            spawn_x = 10'(sx); spawn_y = 9'(sy); spawn_vx = 4'(svx); spawn_vy = 4'(svy);
            spawn_valid = 1'b1;
        end
        tick();
        frame_start = 1'b0;
        spawn_valid = 1'b0;
        if (sp) m_insert(sx, sy, svx, svy);
        for (int i = 0; i < N; i++) begin
            if (i == kslot) begin kill_valid = 1'b1; kill_id = 3'(i); end
            tick();
            kill_valid = 1'b0;
        end
        tick();
        tick();
        m_frame(kslot);
    endtask

    task automatic probe_exp(input int px, input int py, input bit ed, input int eid, input string nm);
        logic [11:0] exp_rgb;
        pxl_x = 10'(px); pxl_y = 9'(py);
        tick();
        tick();
        exp_rgb = ed ? PALETTE[eid] : 12'h000;
        check({nm, ".draw"}, 32'(Draw), 32'(ed));
        check({nm, ".id"}, 32'(hit_id), ed ? 32'(eid) : 32'd0);
        check({nm, ".rgb"}, 32'({Red, Green, Blue}), 32'(exp_rgb));
    endtask

    task automatic probe(input int px, input int py, input string nm);
        int id = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + 32 &&
                py >= m_y[i] && py < m_y[i] + 32) id = i;
        probe_exp(px, py, id >= 0, id < 0 ? 0 : id, nm);
    endtask

    probe_vec_t tbl[10];

    initial begin
        m_reset();
        #12;
        check("rst.draw", 32'(Draw), 0);
        check("rst.id", 32'(hit_id), 0);
        check("rst.rgb", 32'({Red, Green, Blue}), 0);
        check("rst.mask", 32'(active_mask), 0);
        check("rst.ready", 32'(spawn_ready), 0);
        @(negedge clk);
        resetN = 1'b1;
        tick();
        check("ready_after_reset", 32'(spawn_ready), 1);

        // Basic motion.
        do_spawn(100, 50, 3, -2, -1);
        frame(-1, 0, 0, 0, 0, 0);
        check("basic.x", 32'(dut.pos_x[0]), 103);
        check("basic.y", 32'(dut.pos_y[0]), 48);
        check("basic.mask", 32'(active_mask), 32'h01);

        // Wrap on both edges.
        do_reset();
        do_spawn(606, 1, 5, -4, -1);
        frame(-1, 0, 0, 0, 0, 0);
        check("wrap.x", 32'(dut.pos_x[0]), 2);
        check("wrap.y", 32'(dut.pos_y[0]), 446);

        // Full table, kill frees slot 3, next spawn reuses it.
        do_reset();
        for (int i = 0; i < N; i++) do_spawn(20 * i, 10 * i, 1, 1, -1);
        check("full.ready", 32'(spawn_ready), 0);
        check_state("full");
        kill_valid = 1'b1; kill_id = 3'd3;
        tick();
        kill_valid = 1'b0;
        m_act[3] = 0;
        check("kill.ready_stale", 32'(spawn_ready), 0);
        tick();
        check("kill.ready", 32'(spawn_ready), 1);
        do_spawn(77, 88, 1, 1, -1);
        check("reuse.x3", 32'(dut.pos_x[3]), 77);
        check("reuse.mask", 32'(active_mask), 32'hFF);

        // Spawn and kill together: freed slot not reused in that cycle.
        kill_valid = 1'b1; kill_id = 3'd5;
        tick();
        kill_valid = 1'b0;
        m_act[5] = 0;
        tick();
        do_spawn(300, 301, 0, 0, 6);
        check("spkill.x5", 32'(dut.pos_x[5]), 300);
        check("spkill.mask", 32'(active_mask), 32'hBF);
        do_spawn(400, 401, 0, 0, -1);
        check("spkill.x6", 32'(dut.pos_x[6]), 400);
        check_state("spkill");

        // Spawn accepted together with frame_start moves in that frame.
        do_reset();
        do_spawn(10, 10, 1, 1, -1);
        frame(-1, 1, 300, 200, -3, 2);
        check("fs_spawn.x1", 32'(dut.pos_x[1]), 297);
        check("fs_spawn.y1", 32'(dut.pos_y[1]), 202);
        check_state("fs_spawn");

        // Overlap priority table.
        do_reset();
        do_spawn(10, 10, 0, 0, -1);
        do_spawn(200, 200, 0, 0, -1);
        do_spawn(400, 300, 0, 0, -1);
        do_spawn(500, 100, 0, 0, -1);
        do_spawn(200, 200, 0, 0, -1);
        tbl[0] = '{210, 210, 1'b1, 1};
        tbl[1] = '{200, 200, 1'b1, 1};
        tbl[2] = '{231, 231, 1'b1, 1};
        tbl[3] = '{232, 210, 1'b0, 0};
        tbl[4] = '{199, 210, 1'b0, 0};
        tbl[5] = '{10, 10, 1'b1, 0};
        tbl[6] = '{41, 41, 1'b1, 0};
        tbl[7] = '{42, 41, 1'b0, 0};
        tbl[8] = '{400, 300, 1'b1, 2};
        tbl[9] = '{0, 0, 1'b0, 0};
        for (int i = 0; i < 10; i++)
            probe_exp(tbl[i].px, tbl[i].py, tbl[i].draw, tbl[i].id, $sformatf("tbl%0d", i));
        kill_valid = 1'b1; kill_id = 3'd1;
        tick();
        kill_valid = 1'b0;
        m_act[1] = 0;
        probe_exp(210, 210, 1'b1, 4, "after_kill1");

        // Kill during the UPDATE cycle that visits slot 2.
        do_reset();
        for (int i = 0; i < 4; i++) do_spawn(50 + 60 * i, 40 + 30 * i, 2, -1, -1);
        frame(2, 0, 0, 0, 0, 0);
        check("upd_kill.mask", 32'(active_mask), 32'h0B);
        check("upd_kill.x2", 32'(dut.pos_x[2]), 170);
        check("upd_kill.y2", 32'(dut.pos_y[2]), 100);
        check_state("upd_kill");

        // Randomized operations against the model.
        do_reset();
        for (int it = 0; it < 60; it++) begin
            int op = $urandom_range(0, 4);
            int f = m_free();
            case (op)
                0, 4: if (f >= 0) begin
                    int kid = -1;
                    if (op == 4) begin
                        kid = $urandom_range(0, N - 1);
                        if (kid == f) kid = -1;
                    end
                    do_spawn($urandom_range(0, LX), $urandom_range(0, LY),
                             int'($urandom_range(0, 15)) - 8,
                             int'($urandom_range(0, 15)) - 8, kid);
                end
                1: begin
                    int k = $urandom_range(0, N - 1);
                    kill_valid = 1'b1; kill_id = 3'(k);
                    tick();
                    kill_valid = 1'b0;
                    m_act[k] = 0;
                    tick();
                end
                2: begin
                    int k = $urandom_range(0, 15);
                    frame(k < N ? k : -1, 0, 0, 0, 0, 0);
                end
                default: begin
                    int j = $urandom_range(0, N - 1);
                    int px = m_x[j] + $urandom_range(0, 40) - 4;
                    int py = m_y[j] + $urandom_range(0, 40) - 4;
                    if (px < 0) px = 0;
                    if (px > 639) px = 639;
                    if (py < 0) py = 0;
                    if (py > 479) py = 479;
                    probe(px, py, $sformatf("rnd_probe%0d", it));
                end
            endcase
            check_state($sformatf("rnd%0d", it));
        end

        // Reset in the middle of UPDATE.
        do_reset();
        do_spawn(0, 0, 0, 0, -1);
        probe_exp(5, 5, 1'b1, 0, "pre_reset");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        resetN = 1'b0;
        #1;
        check("midrst.draw", 32'(Draw), 0);
        check("midrst.rgb", 32'({Red, Green, Blue}), 0);
        check("midrst.id", 32'(hit_id), 0);
        check("midrst.mask", 32'(active_mask), 0);
        check("midrst.ready", 32'(spawn_ready), 0);
        #2;
        resetN = 1'b1;
        m_reset();
        tick();
        check("midrst.ready_after", 32'(spawn_ready), 1);
        check_state("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
